// File: rtl/sisc_exec_unit_if.sv
// rtl/sisc_exec_unit_if.sv - instruction/operand inputs and write-back/status outputs of the SISC execute slice
interface sisc_exec_unit_if;
  logic [31:0] instruction;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic [1:0]  alu_op;
  logic        wb_sel;
  logic        rf_we;
  logic [31:0] write_data;
  logic [31:0] alu_result;
  logic [3:0]  stat;
  logic        stat_en;

  modport master (
    output instruction, rsa, rsb,
    input  alu_op, wb_sel, rf_we, write_data, alu_result, stat, stat_en
  );

  modport slave (
    input  instruction, rsa, rsb,
    output alu_op, wb_sel, rf_we, write_data, alu_result, stat, stat_en
  );
endinterface

// File: rtl/sisc_exec_unit.sv
// rtl/sisc_exec_unit.sv - SISC ctrl FSM, ALU with flag register, and write-back select
module sisc_exec_unit (
  input logic            clk,
  input logic            rst_f,
  sisc_exec_unit_if.slave bus
);
  typedef enum logic [2:0] {
    START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED
  } state_t;

  localparam logic [3:0] OP_REG  = 4'h1;
  localparam logic [3:0] OP_IMM  = 4'h2;
  localparam logic [3:0] OP_HALT = 4'hF;

  state_t      state, state_nxt;
  logic [3:0]  opcode, mm;
  logic [15:0] imm;
  logic [1:0]  alu_op;
  logic        wb_sel;
  logic        rf_we;
  logic [31:0] alu_result;
  logic [3:0]  stat;
  logic        stat_en;
  logic        unused_fields;

  assign opcode        = bus.instruction[31:28];
  assign mm            = bus.instruction[27:24];
  assign imm           = bus.instruction[15:0];
  assign unused_fields = ^bus.instruction[23:16];

  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) state <= START0;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      START0:    state_nxt = START1;
      START1:    state_nxt = FETCH;
      FETCH:     state_nxt = DECODE;
      DECODE:    state_nxt = (opcode == OP_HALT) ? HALTED : EXECUTE;
      EXECUTE:   state_nxt = MEM;
      MEM:       state_nxt = WRITEBACK;
      WRITEBACK: state_nxt = FETCH;
      HALTED:    state_nxt = HALTED;
      default:   state_nxt = START0;
    endcase
  end

  always_comb begin
    alu_op = 2'b00;
    rf_we  = 1'b0;
    wb_sel = 1'b0;
    if (state == EXECUTE) begin
      if (opcode == OP_REG)      alu_op = 2'b10;
      else if (opcode == OP_IMM) alu_op = 2'b11;
    end
    if (state == WRITEBACK && (opcode == OP_REG || opcode == OP_IMM))
      rf_we = 1'b1;
  end

  logic [31:0] op_a, op_b, b_add, res;
  logic [32:0] sum;
  logic [4:0]  sh;
  logic        is_sub, c_flag, v_flag;

  assign op_a   = bus.rsa;
  assign op_b   = alu_op[0] ? {16'h0, imm} : bus.rsb;
  assign sh     = op_b[4:0];
  assign is_sub = (mm == 4'd1);
  // SUB shares the adder as A + ~B + 1 so carry-out reads as "no borrow"
  assign b_add  = is_sub ? ~op_b : op_b;
  assign sum    = {1'b0, op_a} + {1'b0, b_add} + {32'b0, is_sub};

  always_comb begin
    res    = op_a;
    c_flag = 1'b0;
    v_flag = 1'b0;
    case (mm)
      4'd0, 4'd1: begin
        res    = sum[31:0];
        c_flag = sum[32];
        v_flag = (op_a[31] == b_add[31]) && (sum[31] != op_a[31]);
      end
      4'd2:    res = op_a & op_b;
      4'd3:    res = op_a | op_b;
      4'd4:    res = op_a ^ op_b;
      4'd5:    res = ~op_a;
      4'd6:    res = op_a << sh;
      4'd7:    res = op_a >> sh;
      4'd8:    res = (op_a << sh) | (op_a >> (6'd32 - {1'b0, sh}));
      4'd9:    res = (op_a >> sh) | (op_a << (6'd32 - {1'b0, sh}));
      default: res = op_a;
    endcase
  end

  // EXECUTE always exits to MEM, so capturing here lands stat_en exactly in MEM
  always_ff @(posedge clk or posedge rst_f) begin
    if (rst_f) begin
      alu_result <= 32'h0;
      stat       <= 4'b0000;
      stat_en    <= 1'b0;
    end else begin
      stat_en <= (state == EXECUTE) && alu_op[1];
      if ((state == EXECUTE) && alu_op[1]) begin
        alu_result <= res;
        stat       <= {c_flag, v_flag, res[31], (res == 32'h0)};
      end
    end
  end

  assign bus.alu_op     = alu_op;
  assign bus.rf_we      = rf_we;
  assign bus.wb_sel     = wb_sel;
  assign bus.alu_result = alu_result;
  assign bus.stat       = stat;
  assign bus.stat_en    = stat_en;
  assign bus.write_data = wb_sel ? 32'h0 : alu_result;
endmodule

// File: tb/tb_sisc_exec_unit.sv
// tb/tb_sisc_exec_unit.sv - directed and randomized checks of sisc_exec_unit against a flag/result model
module tb_sisc_exec_unit;
  logic clk = 1'b0;
  logic rst_f;
  int   n_cmp = 0;
  int   n_bad = 0;
  logic [31:0] exp_res;
  logic [3:0]  exp_stat;

  sisc_exec_unit_if bus ();

  sisc_exec_unit dut (
    .clk   (clk),
    .rst_f (rst_f),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Reference: flags from wide signed/unsigned arithmetic, rotates bit by bit
  function automatic void model(input logic [3:0] mm, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f);
    longint ua, ub, sa, sb, full, s;
    logic c, v;
    int sh;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    sh = b % 32;
    c = 0; v = 0; r = a;
    case (mm)
      0: begin
        full = ua + ub; r = a + b; c = (full > 64'h0000_0000_FFFF_FFFF);
        s = sa + sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      1: begin
        r = a - b; c = (ua >= ub);
        s = sa - sb; v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2: r = a & b;
      3: r = a | b;
      4: r = a ^ b;
      5: r = ~a;
      6: r = a << sh;
      7: r = a >> sh;
      8: for (int i = 0; i < sh; i++) r = {r[30:0], r[31]};
      9: for (int i = 0; i < sh; i++) r = {r[0], r[31:1]};
      default: r = a;
    endcase
    f = {c, v, r[31], r == 32'h0};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Called at a negedge with the DUT in FETCH; returns at the negedge of the next FETCH
  task automatic run_instr(input logic [3:0] op, input logic [3:0] mm, input logic [31:0] a,
                           input logic [31:0] b, input logic [15:0] imm, input bit abort_in_wb);
    bit exec;
    logic [31:0] r;
    logic [3:0]  f;
    exec = (op == 4'h1) || (op == 4'h2);
    bus.instruction = {op, mm, 4'h3, 4'h2, imm};
    bus.rsa = a;
    bus.rsb = b;
    if (exec) begin
      model(mm, a, (op == 4'h2) ? {16'h0, imm} : b, r, f);
      exp_res  = r;
      exp_stat = f;
    end
    step();
    chk("decode_alu_op", {30'h0, bus.alu_op}, 32'h0);
    step();
    chk("exec_alu_op", {30'h0, bus.alu_op}, exec ? ((op == 4'h2) ? 32'd3 : 32'd2) : 32'd0);
    step();
    chk("mem_stat_en", {31'h0, bus.stat_en}, {31'h0, exec});
    chk("mem_alu_result", bus.alu_result, exp_res);
    chk("mem_stat", {28'h0, bus.stat}, {28'h0, exp_stat});
    step();
    chk("wb_rf_we", {31'h0, bus.rf_we}, {31'h0, exec});
    chk("wb_sel", {31'h0, bus.wb_sel}, 32'h0);
    chk("wb_write_data", bus.write_data, exp_res);
    chk("wb_stat_en", {31'h0, bus.stat_en}, 32'h0);
    if (abort_in_wb) begin
      #1 rst_f = 1'b1;
      #1;
      exp_res = 32'h0; exp_stat = 4'h0;
      chk("abort_rf_we", {31'h0, bus.rf_we}, 32'h0);
      chk("abort_write_data", bus.write_data, 32'h0);
      chk("abort_stat", {28'h0, bus.stat}, 32'h0);
      @(negedge clk);
      rst_f = 1'b0;
      step();
      step();
    end else begin
      step();
      chk("fetch_rf_we", {31'h0, bus.rf_we}, 32'h0);
      chk("fetch_stat_en", {31'h0, bus.stat_en}, 32'h0);
    end
  endtask

  task automatic do_reset();
    rst_f = 1'b1;
    @(negedge clk);
    @(negedge clk);
    exp_res = 32'h0; exp_stat = 4'h0;
    chk("rst_alu_result", bus.alu_result, 32'h0);
    chk("rst_write_data", bus.write_data, 32'h0);
    chk("rst_stat", {28'h0, bus.stat}, 32'h0);
    chk("rst_enables", {28'h0, bus.alu_op, bus.rf_we, bus.stat_en}, 32'h0);
    rst_f = 1'b0;
    step();
    step();
  endtask

  initial begin
    logic [3:0]  op, mm;
    logic [31:0] a, b;
    logic [31:0] hold_res;
    logic [3:0]  hold_stat;
    bus.instruction = 32'h0;
    bus.rsa = 32'h0;
    bus.rsb = 32'h0;
    do_reset();

    run_instr(4'h1, 4'd0, 32'h0000_0005, 32'h0000_0003, 16'h0, 0);
    run_instr(4'h1, 4'd0, 32'h7FFF_FFFF, 32'h0000_0001, 16'h0, 0);
    run_instr(4'h1, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 16'h0, 0);
    chk("carry_zero_stat", {28'h0, exp_stat}, 32'h9);
    run_instr(4'h2, 4'd1, 32'h0000_0010, 32'hDEAD_BEEF, 16'h0010, 0);
    run_instr(4'h1, 4'd8, 32'h8000_0001, 32'h0000_0001, 16'h0, 0);
    run_instr(4'h1, 4'd5, 32'h0000_0000, 32'h0000_0000, 16'h0, 0);
    run_instr(4'h0, 4'd0, 32'h1234_5678, 32'h1111_1111, 16'h0, 0);
    run_instr(4'h9, 4'd0, 32'h1234_5678, 32'h1111_1111, 16'h0, 0);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 5))
        0:       op = 4'h0;
        1, 2:    op = 4'h1;
        3, 4:    op = 4'h2;
        default: op = 4'($urandom_range(3, 14));
      endcase
      mm = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       a = 32'h7FFF_FFFF;
        1:       a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      run_instr(op, mm, a, b, 16'($urandom), 0);
    end

    run_instr(4'h1, 4'd0, 32'h0000_0005, 32'h0000_0003, 16'h0, 1);
    run_instr(4'h2, 4'd4, 32'hA5A5_0000, 32'h0, 16'hFFFF, 0);

    hold_res  = exp_res;
    hold_stat = exp_stat;
    bus.instruction = {4'hF, 4'd0, 24'h0};
    step();
    step();
    for (int i = 0; i < 25; i++) begin
      chk("halt_enables", {28'h0, bus.alu_op, bus.rf_we, bus.stat_en}, 32'h0);
      chk("halt_hold", {bus.stat, bus.alu_result[27:0]}, {hold_stat, hold_res[27:0]});
      bus.instruction = {4'h1, 28'h0};
      step();
    end

    do_reset();
    run_instr(4'h1, 4'd3, 32'hF0F0_0000, 32'h0000_0F0F, 16'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sisc_exec_unit.md
# sisc_exec_unit

Execution and control slice of the SISC multi-cycle processor: the `ctrl` state machine, the `alu` with its operand select and status-flag generation, and the `mux32` write-back selector. It takes the current instruction and the two register-file read operands. It drives the register-file write enable and write data, plus the status flags and status-enable consumed by `statreg`. The register file, `mux4` and `statreg` are outside this block.

## Interface
- No parameters; all widths fixed.
- `clk` in 1: single clock, rising-edge active.
- `rst_f` in 1: reset, asynchronous, active-high.
- `instruction` in 32: current instruction, held stable from fetch through writeback. Fields:
  - `[31:28]` opcode
  - `[27:24]` mm (ALU function)
  - `[23:20]` rd
  - `[19:16]` rs
  - `[15:0]` imm
- `rsa` in 32: register-file read port A (operand A).
- `rsb` in 32: register-file read port B (operand B for register ops).
- `alu_op` out 2: bit1 = ALU execute enable; bit0 = B operand is immediate.
- `wb_sel` out 1: write-back select; 0 = ALU result, 1 = constant zero.
- `rf_we` out 1: register-file write enable.
- `write_data` out 32: write-back data to the register file.
- `alu_result` out 32: registered ALU result.
- `stat` out 4: registered flags {C,V,N,Z}.
- `stat_en` out 1: one-cycle pulse meaning `stat` is newly valid.

## Operation
- **Opcodes:**
  - 0000 NOOP
  - 0001 REG_OP (rd ← rs op rt-port)
  - 0010 REG_IM (rd ← rs op zero-extended imm)
  - 1111 HALT
  - All others are executed as NOOP.
- **ctrl FSM states:** START0, START1, FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALTED.
- **FSM transitions:**
  - START0→START1→FETCH→DECODE.
  - DECODE→HALTED if opcode is HALT; otherwise DECODE→EXECUTE.
  - EXECUTE→MEM→WRITEBACK→FETCH.
  - HALTED is left only by reset.
- **Outputs are decoded from the current state and opcode:**
  - In EXECUTE: `alu_op` = 2'b10 for REG_OP, 2'b11 for REG_IM, 2'b00 otherwise.
  - In all other states: `alu_op` = 2'b00.
  - `rf_we` = 1 only in WRITEBACK for REG_OP or REG_IM.
  - `wb_sel` = 0 always for these opcodes; the zero path is reserved.
- **ALU operands:** A = `rsa`; B = `alu_op[0]` ? {16'h0, imm} : `rsb`.
- **ALU function by mm:**
  - 0 ADD
  - 1 SUB (A−B)
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 NOT A
  - 6 SHL A by B[4:0]
  - 7 SHR logical A by B[4:0]
  - 8 ROTL A by B[4:0]
  - 9 ROTR A by B[4:0]
  - 10–15 pass A
- **Flags:**
  - N = result[31].
  - Z = (result == 0).
  - ADD: C = carry out of bit 31; V = signed overflow.
  - SUB: computed as A + ~B + 1; C = carry out (1 means no borrow); V = signed overflow.
  - All other functions: C = V = 0.
- **Result width:** 32 bits, wrap-around; no saturation.
- **mux32:** `write_data` = `wb_sel` ? 32'h0 : `alu_result`. Purely combinational.

## Timing
- **Reset (asserted at any time, asynchronously):**
  - FSM → START0.
  - `alu_result` = 0, `stat` = 4'b0000, `stat_en` = 0.
  - Hence `rf_we` = 0, `alu_op` = 00, `wb_sel` = 0, `write_data` = 0.
- Reset mid-instruction aborts the instruction; no write occurs.
- **Rising edges after reset release:**
  - Edge 1 → START1; edge 2 → FETCH; edge 3 → DECODE.
  - Edge 4 → EXECUTE; edge 5 → MEM; edge 6 → WRITEBACK; edge 7 → FETCH.
  - Steady state: 5 cycles per instruction.
- **ALU register:** captures result and flags on the edge that leaves EXECUTE, only when `alu_op[1]` = 1. Otherwise it holds its value.
- **`stat_en`:** high for exactly the MEM cycle following an ALU execute; 0 at all other times.
- **Write-back:** `rf_we` and `write_data` are valid for the whole WRITEBACK cycle. The register file commits on the edge that ends WRITEBACK.
- **NOOP and unknown opcodes:** cycle through EXECUTE/MEM/WRITEBACK with no `alu_op`, no `stat_en`, no `rf_we`. `alu_result` and `stat` hold.
- **HALT:** all enables are 0 in HALTED; registered outputs hold indefinitely.

## Test plan
- **Reset:**
  - Assert `rst_f` mid-WRITEBACK of a REG_OP → same cycle `rf_we` = 0, `write_data` = 0, `stat` = 0.
  - After release, the FSM takes 3 edges to reach DECODE.
- **REG_OP ADD:** mm = 0, `rsa` = 32'h0000_0005, `rsb` = 32'h0000_0003 → `write_data` = 8, `stat` = 0000, `stat_en` pulses in MEM, `rf_we` = 1 only in WRITEBACK.
- **ADD overflow/carry:**
  - 32'h7FFF_FFFF + 1 → result 32'h8000_0000, `stat` = {0,1,1,0}.
  - 32'hFFFF_FFFF + 1 → result 0, `stat` = {1,0,0,1}.
- **REG_IM SUB:** mm = 1, `rsa` = 32'h10, imm = 16'h0010 (`rsb` = 32'hDEAD_BEEF ignored) → result 0, `stat` = {1,0,0,1}, `alu_op` = 11 in EXECUTE.
- **Logic and rotate:**
  - mm = 8, A = 32'h8000_0001, B = 1 → 32'h0000_0003, `stat` = 0000.
  - mm = 5, A = 0 → 32'hFFFF_FFFF, N = 1.
- **NOOP then HALT:**
  - NOOP → no `rf_we`, no `stat_en`, `alu_result` unchanged.
  - HALT → FSM stays in HALTED for 20+ cycles with all enables 0 until reset.
